disp_bank_arbiter: RTL and testbench

Arbitrated, tear-free display bank for the 16-word seven-segment display path. Four requesters write 16-bit hex words into a shadow bank through a round-robin req/gnt burst handshake. The block copies the shadow bank to the active bank only on a scan-frame boundary. The active bank drives the data0..data15 inputs of the 16-digit display top.

---
 rtl/disp_bank_arbiter.sv | 162 ++++++++++++++++
 tb/tb_disp_bank_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : disp_bank_arbiter
// Description : Four-way round-robin burst writer into a shadow display bank,
//               copied tear-free to the active bank on a scan-frame boundary.
//               Optional macro DISP_ARB_PRIO_EN gives requester 0 fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_bank_arbiter #(
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [3:0]             req,
    input  logic [15:0]            wr_addr,
    input  logic [4*DATA_W-1:0]    wr_data,
    input  logic [3:0]             wr_last,
    input  logic                   frame_tick,
    output logic [3:0]             gnt,
    output logic [3:0]             ack,
    output logic [16*DATA_W-1:0]   data_flat,
    output logic                   commit,
    output logic                   busy
);

    localparam logic [4:0] c_max_burst = 5'(MAX_BURST);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_gnt, w_gnt_nxt;
    logic [1:0]        r_gidx, w_gidx_nxt;
    logic [1:0]        r_ptr, w_ptr_nxt;
    logic [4:0]        r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [1:0]        w_rr_sel, w_cand;
    logic              w_prio0;
    logic              r_dirty, r_commit;
    logic [DATA_W-1:0] r_shadow [16];
    logic [DATA_W-1:0] r_active [16];
    logic              w_beat, w_last, w_commit_go;
    logic [3:0]        w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_addr      = wr_addr[{r_gidx, 2'b00} +: 4];
    assign w_data      = wr_data[{r_gidx, 4'b0000} +: DATA_W];
    assign w_last      = wr_last[r_gidx];
    assign w_beat      = |(r_gnt & req);
    assign w_cnt_inc   = r_cnt + 5'd1;
    assign w_commit_go = frame_tick & r_dirty & (r_state == IDLE);

`ifdef DISP_ARB_PRIO_EN
    assign w_prio0 = req[0];
`else
    assign w_prio0 = 1'b0;
`endif

    // Descending scan so the lowest offset from ptr is the one left standing.
    always_comb begin
        w_rr_sel = r_ptr;
        w_cand   = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            w_cand = r_ptr + 2'(i);
            if (req[w_cand]) begin
                w_rr_sel = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = BURST;
                    w_cnt_nxt   = 5'd0;
                    if (w_prio0) begin
                        w_gidx_nxt = 2'd0;
                    end else begin
                        w_gidx_nxt = w_rr_sel;
                        w_ptr_nxt  = w_rr_sel + 2'd1;
                    end
                    w_gnt_nxt = 4'b0001 << w_gidx_nxt;
                end
            end
            BURST: begin
                if (w_beat) begin
                    w_cnt_nxt = w_cnt_inc;
                end
                // A dropped request is an abort; written beats stay in shadow.
                if (!w_beat || w_last || (w_cnt_inc == c_max_burst)) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = 4'b0000;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_gidx  <= 2'd0;
            r_ptr   <= 2'd0;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Commit only happens in IDLE and beats only in BURST, so they never collide.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_dirty  <= 1'b0;
            r_commit <= 1'b0;
        end else begin
            r_commit <= w_commit_go;
            if (w_commit_go) begin
                for (int i = 0; i < 16; i++) begin
                    r_active[i] <= r_shadow[i];
                end
                r_dirty <= 1'b0;
            end
            if (w_beat) begin
                r_shadow[w_addr] <= w_data;
                r_dirty          <= 1'b1;
            end
        end
    end

    assign gnt    = r_gnt;
    assign ack    = r_gnt & req;
    assign busy   = (r_state == BURST);
    assign commit = r_commit;

    generate
        for (genvar n = 0; n < 16; n++) begin : g_flat
            assign data_flat[n*DATA_W +: DATA_W] = r_active[n];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_disp_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_bank_arbiter
// Description : Scoreboard bench for disp_bank_arbiter with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_bank_arbiter;

    localparam int MAXB = 16;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [3:0]   req = '0;
    logic [15:0]  wr_addr = '0;
    logic [63:0]  wr_data = '0;
    logic [3:0]   wr_last = '0;
    logic         frame_tick = 1'b0;
    logic [3:0]   gnt, ack;
    logic [255:0] data_flat;
    logic         commit, busy;

    disp_bank_arbiter #(.DATA_W(16), .MAX_BURST(MAXB)) dut (
        .CLK(CLK), .RST(RST), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_last(wr_last), .frame_tick(frame_tick), .gnt(gnt), .ack(ack),
        .data_flat(data_flat), .commit(commit), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]   e_gnt;
        logic [3:0]   e_ack;
        logic         e_busy;
        logic         e_commit;
        logic [255:0] e_flat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: granted requester index (-1 when idle) plus the two banks.
    int          m_g, m_cnt, m_ptr;
    bit          m_dirty, m_commit;
    logic [15:0] m_sh [16];
    logic [15:0] m_act [16];

    // Monitor statistics
    int          n_commit, n_g2, cur_len;
    logic [3:0]  prev_gnt = '0;
    logic [3:0]  glog[$];
    int          blog[$];
    logic [3:0]  exp_ord [9];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic m_reset();
        m_g = -1; m_cnt = 0; m_ptr = 0; m_dirty = 0; m_commit = 0;
        for (int i = 0; i < 16; i++) begin
            m_sh[i] = '0;
            m_act[i] = '0;
        end
    endtask

    function automatic int pick(input logic [3:0] r);
`ifdef DISP_ARB_PRIO_EN
        if (r[0]) return 0;
`endif
        for (int k = 0; k < 4; k++) begin
            int c = (m_ptr + k) % 4;
            if (r[c]) begin
                m_ptr = (c + 1) % 4;
                return c;
            end
        end
        return -1;
    endfunction

    task automatic m_step(input logic [3:0] r, input logic [15:0] a, input logic [63:0] d,
                          input logic [3:0] l, input logic t);
        m_commit = 0;
        if (m_g < 0) begin
            if (t && m_dirty) begin
                m_act = m_sh;
                m_commit = 1;
                m_dirty = 0;
            end
            if (r != 4'b0000) begin
                m_g = pick(r);
                m_cnt = 0;
            end
        end else if (r[m_g]) begin
            m_sh[a[4*m_g +: 4]] = d[16*m_g +: 16];
            m_dirty = 1;
            m_cnt++;
            if (l[m_g] || m_cnt == MAXB) m_g = -1;
        end else begin
            m_g = -1;
        end
    endtask

    task automatic cyc(input logic [3:0] r, input logic [15:0] a, input logic [63:0] d,
                       input logic [3:0] l, input logic t);
        exp_t e;
        @(posedge CLK);
        #1;
        m_step(req, wr_addr, wr_data, wr_last, frame_tick);
        req = r; wr_addr = a; wr_data = d; wr_last = l; frame_tick = t;
        e.e_gnt    = (m_g >= 0) ? 4'(1 << m_g) : 4'b0000;
        e.e_ack    = e.e_gnt & r;
        e.e_busy   = (m_g >= 0);
        e.e_commit = m_commit;
        for (int i = 0; i < 16; i++) e.e_flat[16*i +: 16] = m_act[i];
        sb.push_back(e);
    endtask

    task automatic cyc1(input int n, input logic [3:0] a, input logic [15:0] d,
                        input logic l, input logic t);
        cyc(4'(1 << n), 16'(a) << (4*n), 64'(d) << (16*n), 4'(l) << n, t);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(4'b0, 16'b0, 64'b0, 4'b0, 1'b0);
    endtask

    task automatic settle();
        @(negedge CLK);
        #1;
    endtask

    task automatic clr_stats();
        n_commit = 0; n_g2 = 0; cur_len = 0;
        glog.delete();
        blog.delete();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("gnt", 256'(gnt), 256'(e.e_gnt));
                chk("ack", 256'(ack), 256'(e.e_ack));
                chk("busy", 256'(busy), 256'(e.e_busy));
                chk("commit", 256'(commit), 256'(e.e_commit));
                chk("data_flat", data_flat, e.e_flat);
            end
            if (commit) n_commit++;
            if (gnt == 4'b0100) n_g2++;
            if (ack != 4'b0000) cur_len++;
            if (gnt != 4'b0000 && prev_gnt == 4'b0000) glog.push_back(gnt);
            if (gnt == 4'b0000 && prev_gnt != 4'b0000) begin
                blog.push_back(cur_len);
                cur_len = 0;
            end
            prev_gnt = gnt;
        end
    end

    initial begin : stim
        int gcount;
`ifdef DISP_ARB_PRIO_EN
        exp_ord = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd4, 4'd8, 4'd2};
`else
        exp_ord = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd2};
`endif
        m_reset();
        clr_stats();
        #1 RST = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_gnt", 256'(gnt), 256'd0);
        chk("reset_busy", 256'(busy), 256'd0);
        chk("reset_commit", 256'(commit), 256'd0);
        chk("reset_flat", data_flat, 256'd0);
        #2 RST = 1'b1;

        // Idle with periodic frame ticks: nothing is dirty, so no commit.
        for (int i = 0; i < 160; i++) cyc(4'b0, 16'b0, 64'b0, 4'b0, (i % 64) == 0);
        settle();
        chk("idle_no_commit", 256'(n_commit), 256'd0);
        chk("idle_flat", data_flat, 256'd0);

        // Requester 2 four-beat burst then commit.
        clr_stats();
        cyc1(2, 4'd0, 16'h1234, 1'b0, 1'b0);
        cyc1(2, 4'd0, 16'h1234, 1'b0, 1'b0);
        cyc1(2, 4'd1, 16'h5678, 1'b0, 1'b0);
        cyc1(2, 4'd2, 16'h9ABC, 1'b0, 1'b0);
        cyc1(2, 4'd3, 16'hDEF0, 1'b1, 1'b0);
        idle(1);
        cyc(4'b0, 16'b0, 64'b0, 4'b0, 1'b1);
        idle(2);
        settle();
        chk("burst2_gnt_cycles", 256'(n_g2), 256'd4);
        chk("burst2_commits", 256'(n_commit), 256'd1);
        chk("burst2_words", 256'(data_flat[63:0]), 256'(64'hDEF0_9ABC_5678_1234));

        // Frame tick during a burst is ignored; the one after it commits.
        clr_stats();
        cyc1(3, 4'd5, 16'hAAAA, 1'b0, 1'b0);
        cyc1(3, 4'd5, 16'hAAAA, 1'b0, 1'b1);
        cyc1(3, 4'd5, 16'hAAAA, 1'b1, 1'b1);
        idle(1);
        cyc(4'b0, 16'b0, 64'b0, 4'b0, 1'b1);
        idle(2);
        settle();
        chk("midburst_commits", 256'(n_commit), 256'd1);
        chk("midburst_word5", 256'(data_flat[80 +: 16]), 256'(16'hAAAA));

        // Requester 1 holds req for 20 beats without wr_last.
        clr_stats();
        for (int i = 0; i < 20; i++) cyc1(1, 4'(i), 16'(16'h0100 + i), 1'b0, 1'b0);
        idle(3);
        settle();
        gcount = 0;
        foreach (glog[i]) if (glog[i] == 4'b0010) gcount++;
        chk("maxburst_len", 256'((blog.size() > 0) ? blog[0] : -1), 256'(MAXB));
        chk("maxburst_regrant", 256'(gcount), 256'd2);
        chk("maxburst_tail", 256'((blog.size() > 1) ? blog[1] : -1), 256'd2);

        // Reset during a burst after three beats.
        cyc1(2, 4'd7, 16'h7777, 1'b0, 1'b0);
        cyc1(2, 4'd7, 16'h7777, 1'b0, 1'b0);
        cyc1(2, 4'd8, 16'h8888, 1'b0, 1'b0);
        cyc1(2, 4'd9, 16'h9999, 1'b0, 1'b0);
        cyc1(2, 4'd10, 16'hAAAA, 1'b0, 1'b0);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("rst_mid_gnt", 256'(gnt), 256'd0);
        chk("rst_mid_busy", 256'(busy), 256'd0);
        chk("rst_mid_flat", data_flat, 256'd0);
        req = '0; wr_addr = '0; wr_data = '0; wr_last = '0; frame_tick = 1'b0;
        m_reset();
        @(negedge CLK);
        #2 RST = 1'b1;
        clr_stats();
        cyc(4'b0, 16'b0, 64'b0, 4'b0, 1'b1);
        idle(1);
        cyc(4'b0, 16'b0, 64'b0, 4'b0, 1'b1);
        idle(1);
        settle();
        chk("rst_no_commit", 256'(n_commit), 256'd0);

        // Grant order with all four requesting, then with requester 0 quiet.
        clr_stats();
        for (int i = 0; i < 10; i++) cyc(4'b1111, 16'($urandom), {$urandom, $urandom}, 4'b1111, 1'b0);
        for (int i = 0; i < 8; i++) cyc(4'b1110, 16'($urandom), {$urandom, $urandom}, 4'b1111, 1'b0);
        idle(3);
        settle();
        chk("order_count", 256'(glog.size()), 256'd9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("order_%0d", i), 256'((i < glog.size()) ? glog[i] : 4'hF), 256'(exp_ord[i]));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            cyc(4'($urandom_range(0, 15)), 16'($urandom), {$urandom, $urandom},
                4'($urandom & $urandom), ($urandom_range(0, 7) == 0));
        end
        idle(2);
        cyc(4'b0, 16'b0, 64'b0, 4'b0, 1'b1);
        idle(2);
        settle();
        chk("scoreboard_drained", 256'(sb.size()), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
